// File: rtl/int_ctrl_pkg.sv
// Shared core definitions for the interrupt/exception controller:
// FSM state encoding, MIPS ExcCode values and the cause priority encoder.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Reserved instruction beats overflow, which beats the external interrupt.
    function automatic logic [4:0] sel_cause(input logic ri, input logic ovf);
        if (ri)
            return EXC_RI;
        else if (ovf)
            return EXC_OV;
        else
            return EXC_INT;
    endfunction

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line followed by a delay flop
// and an edge detector producing a single-cycle event pulse.
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit BOTH_EDGES  = 1'b1
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_async,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Shift the raw line through the synchronizer chain; delay flop trails the last stage.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], i_async};
            delay_reg <= sync_out;
        end
    end

    generate
        if (BOTH_EDGES) begin : g_both
            assign o_event = sync_out ^ delay_reg;
        end else begin : g_rise
            assign o_event = sync_out & ~delay_reg;
        end
    endgenerate

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception controller: synchronizes an external interrupt,
// arbitrates it against synchronous exceptions and hands a single request
// to the pipeline, tracking the service window until the return.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter bit          BOTH_EDGES   = 1'b1,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_ext_int,
    input  logic        i_ovf,
    input  logic        i_ri,
    input  logic [31:0] i_pc_ex,
    input  logic        i_ie_we,
    input  logic        i_ie_wdata,
    input  logic        i_ack,
    input  logic        i_eret,
    output logic        o_exc_req,
    output logic [4:0]  o_cause,
    output logic [31:0] o_epc,
    output logic [31:0] o_handler_pc,
    output logic        o_ie,
    output logic        o_pending,
    output logic        o_dbl_fault
);

    state_e      state_reg;
    logic        pending_reg;
    logic        ie_reg;
    logic        saved_ie_reg;
    logic [4:0]  cause_reg;
    logic [31:0] epc_reg;
    logic        dbl_fault_reg;
    logic        ext_event;
    logic        take_exc;
    logic        clear_pending;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .BOTH_EDGES  (BOTH_EDGES)
    ) u_sync_edge (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_async  (i_ext_int),
        .o_event  (ext_event)
    );

    assign take_exc      = i_ri | i_ovf | (pending_reg & ie_reg);
    assign clear_pending = (state_reg == ST_REQ) && i_ack && (cause_reg == EXC_INT);

    // Pending flag: a new event always wins over the acknowledge that clears it.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            pending_reg <= 1'b0;
        else if (ext_event)
            pending_reg <= 1'b1;
        else if (clear_pending)
            pending_reg <= 1'b0;
    end

    // Request/service FSM with IE handling, cause/EPC capture and nested-fault tracking.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg     <= ST_IDLE;
            ie_reg        <= 1'b1;
            saved_ie_reg  <= 1'b1;
            cause_reg     <= EXC_INT;
            epc_reg       <= 32'h0;
            dbl_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_ie_we)
                        ie_reg <= i_ie_wdata;
                    if (take_exc) begin
                        state_reg <= ST_REQ;
                        cause_reg <= sel_cause(i_ri, i_ovf);
                        epc_reg   <= i_pc_ex;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        state_reg    <= ST_SERVICE;
                        saved_ie_reg <= ie_reg;
                        ie_reg       <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (i_ri | i_ovf)
                        dbl_fault_reg <= 1'b1;
                    if (i_eret) begin
                        state_reg <= ST_IDLE;
                        ie_reg    <= saved_ie_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_exc_req    = (state_reg == ST_REQ);
    assign o_cause      = cause_reg;
    assign o_epc        = epc_reg;
    assign o_handler_pc = HANDLER_ADDR;
    assign o_ie         = ie_reg;
    assign o_pending    = pending_reg;
    assign o_dbl_fault  = dbl_fault_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: a cycle table for the basic interrupt
// and exception flows, then hand-written sequences for the long corner cases.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        i_clk;
    logic        i_arst_n;
    logic        i_ext_int;
    logic        i_ovf;
    logic        i_ri;
    logic [31:0] i_pc_ex;
    logic        i_ie_we;
    logic        i_ie_wdata;
    logic        i_ack;
    logic        i_eret;
    logic        o_exc_req;
    logic [4:0]  o_cause;
    logic [31:0] o_epc;
    logic [31:0] o_handler_pc;
    logic        o_ie;
    logic        o_pending;
    logic        o_dbl_fault;

    int errors = 0;
    int checks = 0;

    int_ctrl dut (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_ext_int    (i_ext_int),
        .i_ovf        (i_ovf),
        .i_ri         (i_ri),
        .i_pc_ex      (i_pc_ex),
        .i_ie_we      (i_ie_we),
        .i_ie_wdata   (i_ie_wdata),
        .i_ack        (i_ack),
        .i_eret       (i_eret),
        .o_exc_req    (o_exc_req),
        .o_cause      (o_cause),
        .o_epc        (o_epc),
        .o_handler_pc (o_handler_pc),
        .o_ie         (o_ie),
        .o_pending    (o_pending),
        .o_dbl_fault  (o_dbl_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ext;
        logic        ovf;
        logic        ri;
        logic [31:0] pc;
        logic        ack;
        logic        eret;
        logic        req;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic        pend;
        logic        ie;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample 1 time unit later, then drop all pulse inputs.
    task automatic step();
        @(posedge i_clk);
        #1;
        i_ovf   = 1'b0;
        i_ri    = 1'b0;
        i_ie_we = 1'b0;
        i_ack   = 1'b0;
        i_eret  = 1'b0;
    endtask

    initial begin
        // ext  ovf   ri    pc        ack   eret  | req   cause  epc       pend  ie
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 5'd0,  32'h20, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 5'd0,  32'h20, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 5'd0,  32'h20, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 5'd10, 32'h44, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h50, 1'b0, 1'b0, 1'b1, 5'd10, 32'h44, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b0, 1'b0, 5'd10, 32'h44, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0, 5'd10, 32'h44, 1'b0, 1'b1};

        i_arst_n   = 1'b1;
        i_ext_int  = 1'b0;
        i_ovf      = 1'b0;
        i_ri       = 1'b0;
        i_pc_ex    = 32'h0;
        i_ie_we    = 1'b0;
        i_ie_wdata = 1'b0;
        i_ack      = 1'b0;
        i_eret     = 1'b0;
        #1 i_arst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_arst_n = 1'b1;

        // Reset state
        chk("rst_req",     32'(o_exc_req),   32'h0);
        chk("rst_cause",   32'(o_cause),     32'h0);
        chk("rst_epc",     o_epc,            32'h0);
        chk("rst_ie",      32'(o_ie),        32'h1);
        chk("rst_pending", 32'(o_pending),   32'h0);
        chk("rst_dbl",     32'(o_dbl_fault), 32'h0);
        chk("handler_pc",  o_handler_pc,     32'h0000_0100);
        $display("reset: req=%0d ie=%0d pend=%0d", o_exc_req, o_ie, o_pending);

        // Table: ext-int request/ack/eret, then simultaneous RI+Ov
        for (int i = 0; i < 10; i++) begin
            i_ext_int = vecs[i].ext;
            i_ovf     = vecs[i].ovf;
            i_ri      = vecs[i].ri;
            i_pc_ex   = vecs[i].pc;
            i_ack     = vecs[i].ack;
            i_eret    = vecs[i].eret;
            step();
            chk($sformatf("v%0d_req", i),   32'(o_exc_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_cause", i), 32'(o_cause),   32'(vecs[i].cause));
            chk($sformatf("v%0d_epc", i),   o_epc,          vecs[i].epc);
            chk($sformatf("v%0d_pend", i),  32'(o_pending), 32'(vecs[i].pend));
            chk($sformatf("v%0d_ie", i),    32'(o_ie),      32'(vecs[i].ie));
            $display("vec %0d: req=%0d cause=%0d epc=0x%0h pend=%0d ie=%0d",
                     i, o_exc_req, o_cause, o_epc, o_pending, o_ie);
        end

        // Masked interrupt stays pending until IE is written back to 1
        i_ie_we = 1'b1; i_ie_wdata = 1'b0;
        step();
        chk("mask_ie", 32'(o_ie), 32'h0);
        i_ext_int = 1'b0;
        step();
        step();
        chk("mask_pend_lat", 32'(o_pending), 32'h0);
        step();
        chk("mask_pend", 32'(o_pending), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("mask_noreq", 32'(o_exc_req), 32'h0);
        end
        chk("mask_pend_hold", 32'(o_pending), 32'h1);
        $display("masked: pend=%0d req=%0d after 20 cycles", o_pending, o_exc_req);
        i_pc_ex = 32'h60;
        i_ie_we = 1'b1; i_ie_wdata = 1'b1;
        step();
        chk("unmask_ie", 32'(o_ie), 32'h1);
        chk("unmask_req0", 32'(o_exc_req), 32'h0);
        step();
        chk("unmask_req", 32'(o_exc_req), 32'h1);
        chk("unmask_cause", 32'(o_cause), 32'h0);
        chk("unmask_epc", o_epc, 32'h60);
        i_ack = 1'b1;
        step();
        chk("unmask_ack_pend", 32'(o_pending), 32'h0);
        $display("unmask: taken cause=%0d epc=0x%0h", o_cause, o_epc);

        // Ext-int events during SERVICE only set pending (0->1 then 1->0)
        i_ext_int = 1'b1;
        repeat (3) step();
        chk("svc_rise_pend", 32'(o_pending), 32'h1);
        chk("svc_rise_noreq", 32'(o_exc_req), 32'h0);
        i_eret = 1'b1;
        step();
        chk("svc_eret_ie", 32'(o_ie), 32'h1);
        step();
        chk("svc_rise_req", 32'(o_exc_req), 32'h1);
        i_ack = 1'b1;
        step();
        i_ext_int = 1'b0;
        repeat (3) step();
        chk("svc_fall_pend", 32'(o_pending), 32'h1);
        chk("svc_fall_noreq", 32'(o_exc_req), 32'h0);
        i_pc_ex = 32'h70;
        i_eret = 1'b1;
        step();
        step();
        chk("svc_fall_req", 32'(o_exc_req), 32'h1);
        chk("svc_fall_cause", 32'(o_cause), 32'h0);
        chk("svc_fall_epc", o_epc, 32'h70);
        i_ack = 1'b1;
        step();
        $display("service edges: falling edge taken cause=%0d epc=0x%0h", o_cause, o_epc);

        // Nested fault in SERVICE, then async reset while in REQ
        i_ovf = 1'b1;
        step();
        chk("dbl_set", 32'(o_dbl_fault), 32'h1);
        chk("dbl_state", 32'(dut.state_reg), 32'(ST_SERVICE));
        chk("dbl_noreq", 32'(o_exc_req), 32'h0);
        i_eret = 1'b1;
        step();
        chk("dbl_sticky", 32'(o_dbl_fault), 32'h1);
        i_pc_ex = 32'h80;
        i_ri = 1'b1;
        step();
        chk("ri_req", 32'(o_exc_req), 32'h1);
        chk("ri_cause", 32'(o_cause), 32'd10);
        #2 i_arst_n = 1'b0;
        #1;
        chk("arst_req",     32'(o_exc_req),       32'h0);
        chk("arst_cause",   32'(o_cause),         32'h0);
        chk("arst_epc",     o_epc,                32'h0);
        chk("arst_ie",      32'(o_ie),            32'h1);
        chk("arst_pending", 32'(o_pending),       32'h0);
        chk("arst_dbl",     32'(o_dbl_fault),     32'h0);
        chk("arst_state",   32'(dut.state_reg),   32'(ST_IDLE));
        chk("arst_saved",   32'(dut.saved_ie_reg), 32'h1);
        $display("async reset in REQ: req=%0d dbl=%0d ie=%0d", o_exc_req, o_dbl_fault, o_ie);
        repeat (2) @(posedge i_clk);
        #1 i_arst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, setting the number of ext-int synchronizer flops (minimum 2).
REQ-002 The block SHALL have parameter BOTH_EDGES, default 1: 1 = any ext-int toggle is an event; 0 = rising edge only.
REQ-003 The block SHALL have parameter HANDLER_ADDR, default 32'h0000_0100, the exception vector.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  rising-edge clock; i_arst_n  in  1  async active-low reset.
REQ-005 The block SHALL have port i_ext_int  in  1  asynchronous external interrupt line.
REQ-006 The block SHALL have port i_ovf  in  1  overflow exception pulse from execute.
REQ-007 The block SHALL have port i_ri  in  1  reserved-instruction exception pulse from decode/execute.
REQ-008 The block SHALL have port i_pc_ex  in  32  PC of the instruction currently in execute.
REQ-009 The block SHALL have port i_ie_we  in  1  write strobe for the global interrupt enable.
REQ-010 The block SHALL have port i_ie_wdata  in  1  new IE value.
REQ-011 The block SHALL have port i_ack  in  1  pipeline has flushed and redirected to o_handler_pc.
REQ-012 The block SHALL have port i_eret  in  1  return-from-exception retired.
REQ-013 The block SHALL have ports o_exc_req  out  1  exception request to the pipeline; o_cause  out  5  MIPS ExcCode; o_epc  out  32  return PC.
REQ-014 The block SHALL have ports o_handler_pc  out  32  equal to HANDLER_ADDR; o_ie  out  1  current IE; o_pending  out  1  ext-int pending; o_dbl_fault  out  1  sticky nested-fault flag.

Function
REQ-015 i_ext_int SHALL pass through SYNC_STAGES flops plus one delay flop; an event is the synced value differing from the delayed value (rising only when BOTH_EDGES=0).
REQ-016 An event SHALL set o_pending on the next posedge; an event coinciding with clearing SHALL leave pending set.
REQ-017 The FSM SHALL have states IDLE, REQ and SERVICE; o_exc_req=1 only in REQ.
REQ-018 IDLE->REQ SHALL occur on a posedge where i_ri | i_ovf | (o_pending & o_ie); o_cause and o_epc<=i_pc_ex SHALL be captured on the same edge.
REQ-019 Priority SHALL be RI (cause 10) > Ov (cause 12) > Int (cause 0); sync exceptions SHALL be taken regardless of IE.
REQ-020 With SYNC_STAGES=2, an ext-int change before posedge k with IE=1 in IDLE SHALL give o_pending=1 after k+2 and o_exc_req=1 after k+3.
REQ-021 REQ SHALL hold o_exc_req, o_cause and o_epc stable until i_ack; REQ->SERVICE SHALL occur on i_ack, clearing IE (saved copy kept) and clearing o_pending when cause=0.
REQ-022 In SERVICE, ext-int events SHALL only set pending; i_ovf or i_ri SHALL set o_dbl_fault without a state change.
REQ-023 SERVICE->IDLE SHALL occur on i_eret, restoring IE from the saved copy; i_eret in IDLE or REQ SHALL be ignored.
REQ-024 i_ie_we SHALL update IE in IDLE only; in REQ or SERVICE it SHALL be ignored.
REQ-025 A pending interrupt with IE=0 SHALL stay pending indefinitely and be taken one cycle after IE is set.
REQ-026 i_ack outside REQ SHALL be ignored.

Reset
REQ-027 While i_arst_n=0, regardless of state, the block SHALL hold: state IDLE, sync/delay flops 0, o_pending 0, IE 1, saved IE 1, o_cause 0, o_epc 0, o_dbl_fault 0, o_exc_req 0.
REQ-028 o_dbl_fault SHALL clear only on reset.

Structure
REQ-029 The state enum and the ExcCode constants (EXC_INT=0, EXC_RI=10, EXC_OV=12) SHALL live in the shared core package.
REQ-030 The synchronizer SHALL be sub-module sync_edge (parameters SYNC_STAGES, BOTH_EDGES; output a 1-cycle event pulse).

Verification
REQ-031 The bench SHALL cover: IE=1, toggle i_ext_int 0->1, i_pc_ex=0x20 -> o_exc_req after 3 posedges, cause 0, epc 0x20; i_ack -> o_pending 0, o_ie 0; i_eret -> o_ie 1.
REQ-032 The bench SHALL cover: i_ri and i_ovf pulsed in the same cycle, pc 0x44 -> cause 10, epc 0x44.
REQ-033 The bench SHALL cover: IE=0, toggle ext-int -> o_pending 1, no request for 20 cycles; write IE=1 -> o_exc_req on the next cycle.
REQ-034 The bench SHALL cover: BOTH_EDGES=1, ext-int 1->0 while in SERVICE -> pending 1; after i_eret a new request with cause 0.
REQ-035 The bench SHALL cover: i_ovf in SERVICE -> o_dbl_fault 1 and the state stays SERVICE; then assert reset in REQ -> all outputs match the REQ-027 values.
